// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the store buffer between the memory stage and the data RAM.
package store_buffer_pkg;

    // Default geometry of the buffer and the RAM interface.
    localparam int STB_DEPTH = 4;
    localparam int STB_AW    = 32;
    localparam int STB_DW    = 32;

    // Stores are whole words; the two low address bits select a byte and are
    // ignored when comparing addresses.
    localparam int WORD_LSB  = 2;

    // What the FIFO does on a given edge.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } stbOp_e;

endpackage

// File: rtl/stb_fwd_match.sv
// Store-to-load forwarding: compares a load word address against every valid
// buffered store and returns the data of the youngest match.
module stb_fwd_match #(
    parameter int DEPTH = 4,
    parameter int WW    = 30,
    parameter int DW    = 32
) (
    input  logic [DEPTH-1:0][WW-1:0]     entryWord,
    input  logic [DEPTH-1:0][DW-1:0]     entryData,
    input  logic [DEPTH-1:0]             entryValid,
    input  logic [$clog2(DEPTH)-1:0]     tailPtr,
    input  logic [WW-1:0]                addrWord,
    output logic                         hit,
    output logic [DW-1:0]                data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk the entries from oldest (tail-DEPTH) to youngest (tail-1) so a later
    // match overrides an earlier one and the youngest store wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tailPtr - PW'(k);
            if (entryValid[idx] && (entryWord[idx] == addrWord)) begin
                hit  = 1'b1;
                data = entryData[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues word stores from the memory stage, drains them in
// program order over a valid/ready RAM write port and forwards buffered data
// to loads that hit a pending store.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH,
    parameter int AW    = STB_AW,
    parameter int DW    = STB_DW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_write_i,
    input  logic                      mem_read_i,
    input  logic [AW-1:0]             addr_i,
    input  logic [DW-1:0]             wdata_i,
    output logic [DW-1:0]             rdata_o,
    input  logic [DW-1:0]             mem_rdata_i,
    output logic                      stall_o,
    output logic                      wr_valid_o,
    output logic [AW-1:0]             wr_addr_o,
    output logic [DW-1:0]             wr_data_o,
    input  logic                      wr_ready_i,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = AW - WORD_LSB;

    logic [DEPTH-1:0][AW-1:0] entryAddr;
    logic [DEPTH-1:0][DW-1:0] entryData;
    logic [DEPTH-1:0][WW-1:0] entryWord;
    logic [DEPTH-1:0]         entryValid;
    logic [PW-1:0]            headPtr;
    logic [PW-1:0]            tailPtr;
    logic [CW-1:0]            count;

    logic    full;
    logic    empty;
    logic    push;
    logic    pop;
    stbOp_e  op;
    logic    fwdHit;
    logic [DW-1:0] fwdData;

    // Occupancy decides full/empty; pointer equality is ambiguous when wrapped.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop freeing a slot on the same edge does not admit a store into a full buffer.
    assign push    = mem_write_i && !full;
    assign pop     = !empty && wr_ready_i;
    assign stall_o = mem_write_i && full;

    assign wr_valid_o = !empty;
    assign wr_addr_o  = entryAddr[headPtr];
    assign wr_data_o  = entryData[headPtr];
    assign count_o    = count;
    assign empty_o    = empty;

    // Classify this edge's FIFO activity for the occupancy update.
    always_comb begin
        op = OP_IDLE;
        if (push && pop) begin
            op = OP_BOTH;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
    end

    // Pointers, occupancy and valid bits; reset discards every buffered store at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
            entryValid <= '0;
        end else begin
            if (push) begin
                tailPtr             <= tailPtr + PW'(1);
                entryValid[tailPtr] <= 1'b1;
            end
            if (pop) begin
                headPtr             <= headPtr + PW'(1);
                entryValid[headPtr] <= 1'b0;
            end
            unique case (op)
                OP_PUSH: count <= count + CW'(1);
                OP_POP:  count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload is only meaningful under its valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entryAddr[tailPtr] <= addr_i;
            entryData[tailPtr] <= wdata_i;
        end
    end

    // Word-address view of each entry for the forwarding compare.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entryWord[i] = entryAddr[i][AW-1:WORD_LSB];
        end
    end

    stb_fwd_match #(
        .DEPTH (DEPTH),
        .WW    (WW),
        .DW    (DW)
    ) uFwdMatch (
        .entryWord  (entryWord),
        .entryData  (entryData),
        .entryValid (entryValid),
        .tailPtr    (tailPtr),
        .addrWord   (addr_i[AW-1:WORD_LSB]),
        .hit        (fwdHit),
        .data       (fwdData)
    );

    // A store and load together is illegal; the store proceeds and the load sees RAM data.
    assign rdata_o = (mem_read_i && !mem_write_i && fwdHit) ? fwdData : mem_rdata_i;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memWrite;
    logic        memRead;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] memRdata;
    logic        stall;
    logic        wrValid;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic        wrReady;
    logic [2:0]  count;
    logic        empty;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: pending stores in program order, {addr, data}.
    logic [63:0] q[$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_write_i (memWrite),
        .mem_read_i  (memRead),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .mem_rdata_i (memRdata),
        .stall_o     (stall),
        .wr_valid_o  (wrValid),
        .wr_addr_o   (wrAddr),
        .wr_data_o   (wrData),
        .wr_ready_i  (wrReady),
        .count_o     (count),
        .empty_o     (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mw, input logic mr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] mrd, input logic rdy);
        memWrite = mw;
        memRead  = mr;
        addr     = a;
        wdata    = d;
        memRdata = mrd;
        wrReady  = rdy;
    endtask

    // Expected load data: youngest pending store to the same word, else RAM data.
    function automatic logic [31:0] expRdata();
        if (memRead && !memWrite) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i][63:34] == addr[31:2]) return q[i][31:0];
            end
        end
        return memRdata;
    endfunction

    // Check all outputs against the model, advance the model, then cross one edge.
    task automatic cycle(input string tag);
        logic pushOk;
        #1;
        chk({tag, "_wrValid"}, 32'(wrValid), 32'(q.size() != 0));
        chk({tag, "_count"},   32'(count),   32'(q.size()));
        chk({tag, "_empty"},   32'(empty),   32'(q.size() == 0));
        chk({tag, "_stall"},   32'(stall),   32'(memWrite && (q.size() == DEPTH)));
        chk({tag, "_rdata"},   rdata,        expRdata());
        if (q.size() != 0) begin
            chk({tag, "_wrAddr"}, wrAddr, q[0][63:32]);
            chk({tag, "_wrData"}, wrData, q[0][31:0]);
        end
        if (reset) begin
            pushOk = memWrite && (q.size() < DEPTH);
            if (q.size() != 0 && wrReady) void'(q.pop_front());
            if (pushOk) q.push_back({addr, wdata});
        end else begin
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] expA[3];
        int          ready;
        int          guard;

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            drive(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
            cycle("rstHold");
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom));
            cycle("rstRelease");
        end

        // Single store, drained immediately.
        drive(1, 0, 32'h100, 32'hDEADBEEF, 0, 1);
        cycle("single");
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk("single_valid", 32'(wrValid), 32'd1);
        chk("single_addr", wrAddr, 32'h100);
        chk("single_data", wrData, 32'hDEADBEEF);
        cycle("singleDrain");
        #1;
        chk("single_countAfter", 32'(count), 32'd0);

        // Fill, stall on full, drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'(i * 4), 32'hA0 + 32'(i), 0, 0);
            cycle("fill");
        end
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("fill_count", 32'(count), 32'd4);
        drive(1, 0, 32'h10, 32'hA4, 0, 0);
        #1;
        chk("full_stall", 32'(stall), 32'd1);
        cycle("fullHeld");
        drive(1, 0, 32'h10, 32'hA4, 0, 1);
        #1;
        chk("drain0_addr", wrAddr, 32'h0);
        cycle("fullPop");
        #1;
        chk("stallClear", 32'(stall), 32'd0);
        chk("drain1_addr", wrAddr, 32'h4);
        cycle("pushAfterPop");
        expA[0] = 32'h8;
        expA[1] = 32'hC;
        expA[2] = 32'h10;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1);
            #1;
            chk("drainOrder_addr", wrAddr, expA[k]);
            cycle("drain");
        end
        #1;
        chk("drained_empty", 32'(empty), 32'd1);

        // Forwarding: youngest match wins, byte offset ignored, miss goes to RAM.
        drive(1, 0, 32'h200, 32'd1, 0, 0);
        cycle("fwdSt1");
        drive(1, 0, 32'h200, 32'd2, 0, 0);
        cycle("fwdSt2");
        drive(0, 1, 32'h200, 0, 32'h77, 0);
        #1;
        chk("fwd_young", rdata, 32'd2);
        cycle("fwdLd200");
        drive(0, 1, 32'h202, 0, 32'h77, 0);
        #1;
        chk("fwd_byteOff", rdata, 32'd2);
        cycle("fwdLd202");
        drive(0, 1, 32'h204, 0, 32'h55, 0);
        #1;
        chk("fwd_miss", rdata, 32'h55);
        cycle("fwdLd204");
        drive(1, 1, 32'h200, 32'd3, 32'h66, 0);
        #1;
        chk("fwd_illegal", rdata, 32'h66);
        cycle("fwdIllegal");
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            drive(0, 0, 0, 0, 0, 1);
            cycle("fwdDrain");
            guard++;
        end
        chk("fwdDrain_empty", 32'(empty), 32'd1);

        // Push and pop on the same edge keep occupancy.
        drive(1, 0, 32'h300, 32'h11, 0, 0);
        cycle("ppSt1");
        drive(1, 0, 32'h304, 32'h22, 0, 0);
        cycle("ppSt2");
        drive(1, 0, 32'h308, 32'h33, 0, 1);
        #1;
        chk("pp_countBefore", 32'(count), 32'd2);
        cycle("ppBoth");
        #1;
        chk("pp_countAfter", 32'(count), 32'd2);

        // 3*DEPTH stores with toggling ready across pointer wrap; stalled stores are held.
        ready = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            guard = 0;
            do begin
                drive(1, 1'($urandom), 32'h400 + 32'(i * 4), $urandom, $urandom, 1'(ready));
                ready = 1 - ready;
                guard++;
                if (q.size() < DEPTH) begin
                    cycle("wrap");
                    break;
                end
                cycle("wrapStall");
            end while (guard < 10);
        end
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            drive(0, 0, 0, 0, 0, 1);
            cycle("wrapDrain");
            guard++;
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Random traffic on a small address window so loads hit pending stores.
        for (int i = 0; i < 300; i++) begin
            logic mw;
            logic mr;
            mw = ($urandom_range(0, 2) != 0);
            mr = mw ? ($urandom_range(0, 7) == 0) : 1'($urandom);
            drive(mw, mr, 32'h500 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3)),
                  $urandom, $urandom, ($urandom_range(0, 2) == 0));
            cycle("rand");
        end

        // Asynchronous reset while the head is waiting on ready.
        drive(1, 0, 32'h600, 32'hC0, 0, 0);
        cycle("midSt1");
        drive(1, 0, 32'h604, 32'hC1, 0, 0);
        cycle("midSt2");
        drive(0, 0, 0, 0, 32'h99, 0);
        #1;
        chk("mid_validBefore", 32'(wrValid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_validAfter", 32'(wrValid), 32'd0);
        chk("mid_countAfter", 32'(count), 32'd0);
        chk("mid_emptyAfter", 32'(empty), 32'd1);
        q.delete();
        cycle("midRst");
        reset = 1'b1;
        drive(0, 1, 32'h600, 0, 32'h99, 1);
        cycle("midRelease");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
